// File: rtl/fetch_queue.sv
// Instruction fetch front-end: drives the fetch PC into an async ROM and buffers
// returned words with their PCs in a small FIFO feeding the core over valid/ready.
module fetch_queue #(
   parameter int unsigned     XLEN     = 64,
   parameter int unsigned     ILEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   output logic [XLEN-1:0]            rom_addr_o,
   input  logic [ILEN-1:0]            rom_data_i,
   output logic                       inst_valid_o,
   output logic [ILEN-1:0]            inst_o,
   output logic [XLEN-1:0]            inst_pc_o,
   input  logic                       inst_ready_i,
   input  logic                       redirect_valid_i,
   input  logic [XLEN-1:0]            redirect_pc_i,
   output logic [$clog2(DEPTH):0]     fill_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [XLEN-1:0] fetch_pc_q;
   logic [AW-1:0]   rptr_q;
   logic [AW-1:0]   wptr_q;
   logic [CW-1:0]   count_q;
   logic [CW-1:0]   count_d;
   logic            valid_c;
   logic            pop_c;
   logic            push_c;
   logic [XLEN-1:0] redirect_aligned_c;

   logic [ILEN-1:0] inst_mem [DEPTH];
   logic [XLEN-1:0] pc_mem   [DEPTH];

   assign valid_c            = (count_q != '0);
   assign redirect_aligned_c = redirect_pc_i & ~XLEN'(3);

   // Handshake decode; a redirect suppresses both push and pop for the cycle.
   always_comb begin
      pop_c   = 1'b0;
      push_c  = 1'b0;
      count_d = count_q;
      if (!redirect_valid_i) begin
         pop_c   = valid_c & inst_ready_i;
         push_c  = (count_q < CW'(DEPTH)) | pop_c;
         count_d = count_q + CW'(push_c) - CW'(pop_c);
      end
   end

   // Control state: fetch PC, pointers and occupancy.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fetch_pc_q <= RESET_PC;
         rptr_q     <= '0;
         wptr_q     <= '0;
         count_q    <= '0;
      end else if (redirect_valid_i) begin
         fetch_pc_q <= redirect_aligned_c;
         rptr_q     <= '0;
         wptr_q     <= '0;
         count_q    <= '0;
      end else begin
         count_q <= count_d;
         if (push_c) begin
            fetch_pc_q <= fetch_pc_q + XLEN'(4);
            wptr_q     <= wptr_q + AW'(1);
         end
         if (pop_c) begin
            rptr_q <= rptr_q + AW'(1);
         end
      end
   end

   // Storage needs no reset: entries are only visible behind a nonzero count.
   always_ff @(posedge clk_i) begin
      if (push_c) begin
         inst_mem[wptr_q] <= rom_data_i;
         pc_mem[wptr_q]   <= fetch_pc_q;
      end
   end

   assign rom_addr_o   = fetch_pc_q;
   assign inst_valid_o = valid_c;
   assign inst_o       = valid_c ? inst_mem[rptr_q] : '0;
   assign inst_pc_o    = valid_c ? pc_mem[rptr_q]   : '0;
   assign fill_o       = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus loads expected PC streams, a
// negedge monitor pops and checks every accepted instruction.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] rom_addr;
   logic [31:0] rom_data;
   logic        inst_valid;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic        inst_ready;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic [2:0]  fill;

   int          n_cmp = 0;
   int          n_err = 0;
   int          acc_cnt = 0;
   int          a0;
   logic [63:0] exp_q [$];

   fetch_queue #(.XLEN(64), .ILEN(32), .DEPTH(4), .RESET_PC(64'h0)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .rom_addr_o       (rom_addr),
      .rom_data_i       (rom_data),
      .inst_valid_o     (inst_valid),
      .inst_o           (inst),
      .inst_pc_o        (inst_pc),
      .inst_ready_i     (inst_ready),
      .redirect_valid_i (redirect_valid),
      .redirect_pc_i    (redirect_pc),
      .fill_o           (fill)
   );

   always #5 clk = ~clk;

   // ROM word k holds 0x1000_0000 + k.
   assign rom_data = 32'h1000_0000 + rom_addr[33:2];

   function automatic logic [31:0] exp_inst(input logic [63:0] pc);
      return 32'h1000_0000 + pc[33:2];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic load_exp(input logic [63:0] start);
      exp_q.delete();
      for (int i = 0; i < 2000; i++) exp_q.push_back(start + 64'(4 * i));
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Monitor: an accept is valid & ready with no redirect at the coming edge.
   always @(negedge clk) begin
      if (!rst) begin
         chk("fill_le_depth", 64'(fill > 3'd4), 64'd0);
         if (inst_valid && inst_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL acc_underflow: got pc %h expected none", inst_pc);
            end else begin
               logic [63:0] e;
               e = exp_q.pop_front();
               chk("acc_pc", inst_pc, e);
               chk("acc_inst", 64'(inst), 64'(exp_inst(e)));
            end
            acc_cnt++;
         end
      end
   end

   initial begin
      rst = 1'b1;
      inst_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      load_exp(64'h0);
      step();
      step();
      chk("rst_valid", 64'(inst_valid), 64'd0);
      chk("rst_fill", 64'(fill), 64'd0);
      chk("rst_addr", rom_addr, 64'h0);
      chk("rst_inst", 64'(inst), 64'd0);
      chk("rst_pc", inst_pc, 64'h0);

      // Startup fill with ready held low.
      rst = 1'b0;
      step();
      chk("first_valid", 64'(inst_valid), 64'd1);
      chk("first_fill", 64'(fill), 64'd1);
      repeat (5) step();
      chk("full_fill", 64'(fill), 64'd4);
      chk("full_addr", rom_addr, 64'h10);
      chk("full_head_pc", inst_pc, 64'h0);
      chk("full_head_inst", 64'(inst), 64'h1000_0000);

      // Streaming while full: one accept per cycle, fill pinned at 4.
      inst_ready = 1'b1;
      a0 = acc_cnt;
      repeat (20) begin
         step();
         chk("stream_fill", 64'(fill), 64'd4);
         chk("stream_valid", 64'(inst_valid), 64'd1);
      end
      chk("stream_accepts", 64'(acc_cnt - a0), 64'd20);

      // Random backpressure.
      repeat (1000) begin
         inst_ready = 1'($urandom_range(0, 1));
         step();
      end

      // Refill, then redirect while full with ready high.
      inst_ready = 1'b0;
      repeat (5) step();
      chk("pre_redir_fill", 64'(fill), 64'd4);
      inst_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 64'h0000_0000_0000_0103;
      load_exp(64'h100);
      a0 = acc_cnt;
      step();
      redirect_valid = 1'b0;
      chk("redir_bubble", 64'(inst_valid), 64'd0);
      chk("redir_fill", 64'(fill), 64'd0);
      chk("redir_addr", rom_addr, 64'h100);
      step();
      chk("redir_head0", inst_pc, 64'h100);
      step();
      chk("redir_head1", inst_pc, 64'h104);
      repeat (2) step();
      chk("redir_accepts", 64'(acc_cnt - a0), 64'd3);

      // PC wrap at the top of the address space.
      redirect_valid = 1'b1;
      redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
      load_exp(64'hFFFF_FFFF_FFFF_FFF8);
      a0 = acc_cnt;
      step();
      redirect_valid = 1'b0;
      repeat (5) step();
      chk("wrap_accepts", 64'(acc_cnt - a0), 64'd4);
      chk("wrap_head", inst_pc, 64'h8);

      // Asynchronous reset between edges.
      step();
      #1;
      rst = 1'b1;
      #1;
      chk("arst_valid", 64'(inst_valid), 64'd0);
      chk("arst_fill", 64'(fill), 64'd0);
      chk("arst_addr", rom_addr, 64'h0);
      load_exp(64'h0);
      step();
      step();
      rst = 1'b0;
      a0 = acc_cnt;
      repeat (4) step();
      chk("arst_accepts", 64'(acc_cnt - a0), 64'd3);
      chk("arst_head", inst_pc, 64'hC);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
